// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: start/data/optional parity/stop framing with one-cycle result pulses.
// Define UART_RX_MAJORITY_VOTE_EN to take each bit as a 2-of-3 vote around mid-bit instead of one sample.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            PRESCALE,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;

  // Bit index within the frame: start bit is 0, data bits are 1..DATA_WIDTH.
  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  state_t                state, state_next;
  logic [5:0]            tick, tick_next;
  logic [3:0]            bit_cnt, bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift, shift_next;
  logic                  par_flag, par_flag_next;
  logic                  stop_bit, stop_bit_next;
  logic [5:0]            ps_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  latch_cfg;
  logic                  frame_done;
  logic [5:0]            half;
  logic                  tick_wrap;
  logic                  at_decide;
  logic                  cur_bit;

  assign half      = {1'b0, ps_q[5:1]};
  assign tick_wrap = (tick == ps_q - 6'd1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic early_s;
  logic mid_s;

  // The two earlier votes are held until the third arrives one tick after mid-bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      early_s <= 1'b0;
      mid_s   <= 1'b0;
    end else begin
      if (tick == half - 6'd1) early_s <= RX_IN;
      if (tick == half)        mid_s   <= RX_IN;
    end
  end

  assign at_decide = (tick == half + 6'd1);
  assign cur_bit   = (early_s & mid_s) | (early_s & RX_IN) | (mid_s & RX_IN);
`else
  assign at_decide = (tick == half);
  assign cur_bit   = RX_IN;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      tick      <= 6'd0;
      bit_cnt   <= 4'd0;
      shift     <= '0;
      par_flag  <= 1'b0;
      stop_bit  <= 1'b0;
      ps_q      <= 6'd0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state    <= state_next;
      tick     <= tick_next;
      bit_cnt  <= bit_cnt_next;
      shift    <= shift_next;
      par_flag <= par_flag_next;
      stop_bit <= stop_bit_next;
      if (latch_cfg) begin
        ps_q      <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

  // The IDLE cycle that sees the line low is already tick 0 of the start bit.
  always_comb begin
    state_next    = state;
    tick_next     = tick;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    par_flag_next = par_flag;
    stop_bit_next = stop_bit;
    latch_cfg     = 1'b0;
    frame_done    = 1'b0;

    if (state == IDLE) begin
      tick_next     = 6'd0;
      bit_cnt_next  = 4'd0;
      par_flag_next = 1'b0;
      if (!RX_IN) begin
        state_next = START;
        tick_next  = 6'd1;
        latch_cfg  = 1'b1;
      end
    end else begin
      tick_next = tick_wrap ? 6'd0 : tick + 6'd1;
      if (tick_wrap) bit_cnt_next = bit_cnt + 4'd1;
    end

    unique case (state)
      IDLE: ;
      START: begin
        if (at_decide && cur_bit) begin
          state_next   = IDLE;
          tick_next    = 6'd0;
          bit_cnt_next = 4'd0;
        end else if (tick_wrap) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (at_decide) shift_next = {cur_bit, shift[DATA_WIDTH-1:1]};
        if (tick_wrap && bit_cnt == LAST_DATA) state_next = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (at_decide && (cur_bit != (^shift ^ par_typ_q))) par_flag_next = 1'b1;
        if (tick_wrap) state_next = STOP;
      end
      STOP: begin
        if (at_decide) stop_bit_next = cur_bit;
        if (tick_wrap) begin
          state_next = IDLE;
          tick_next  = 6'd0;
          frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Exactly one result pulse per completed frame; parity error outranks a bad stop bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (frame_done) begin
        if (par_flag) begin
          PAR_ERR <= 1'b1;
        end else if (!stop_bit) begin
          STP_ERR <= 1'b1;
        end else begin
          DATA_VALID <= 1'b1;
          P_DATA     <= shift;
        end
      end
    end
  end

endmodule
